// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, DMA gets a forced slot after
// MAX_WAIT consecutive denied cycles. Memory read path is combinational.
module dmem_arbiter #(
  parameter int DSIZE    = 16,
  parameter int AW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DSIZE-1:0] cpu_wdata,
  output logic [DSIZE-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [AW-1:0]    dma_addr,
  input  logic [DSIZE-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic [DSIZE-1:0] dma_rdata,
  output logic             dma_rvalid,
  output logic             mem_wen,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [1:0]       owner,
  output logic [15:0]      stall_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [3:0]       wait_q, wait_d;
  logic [DSIZE-1:0] dma_rdata_q, dma_rdata_d;
  logic             dma_rvalid_q, dma_rvalid_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic force_slot;
  logic dma_gnt_w;
  logic cpu_gnt_w;

  // Grant: nothing is issued while rst is high.
  always_comb begin
    force_slot = dma_req && (wait_q == MAX_WAIT_C);
    dma_gnt_w  = !rst && dma_req && (!cpu_req || force_slot);
    cpu_gnt_w  = !rst && cpu_req && !dma_gnt_w;
  end

  assign dma_gnt   = dma_gnt_w;
  assign cpu_stall = !rst && cpu_req && dma_gnt_w;

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (dma_gnt_w) begin
      mem_wen   = dma_we;
      mem_ren   = !dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_gnt_w) begin
      mem_wen   = cpu_we;
      mem_ren   = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) cpu_rdata = mem_rdata;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (dma_gnt_w)      owner_d = OWN_DMA;
    else if (cpu_gnt_w) owner_d = OWN_CPU;
  end

  always_comb begin
    wait_d = 4'd0;
    if (dma_req && !dma_gnt_w)
      wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 4'd1;

    dma_rvalid_d = dma_gnt_w && !dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;

    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_IDLE;
      wait_q       <= 4'd0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      owner_q      <= owner_d;
      wait_q       <= wait_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign owner      = owner_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int DSIZE    = 16;
  localparam int AW       = 16;
  localparam int MAX_WAIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0]    cpu_addr, dma_addr, mem_addr;
  logic [DSIZE-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic             cpu_stall, dma_gnt, dma_rvalid, mem_wen, mem_ren;
  logic [1:0]       owner;
  logic [15:0]      stall_cnt;

  dmem_arbiter #(.DSIZE(DSIZE), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: how long DMA has been waiting, who last used memory, etc.
  int m_wait, m_owner, m_stall;
  logic m_rvalid;
  logic [15:0] m_rdata;

  // Combinational results of the most recent cycle, for directed checks.
  logic obs_dg, obs_st, obs_wen, obs_ren;
  logic [15:0] obs_addr, obs_wdata, obs_crd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic creq, input logic cwe,
                     input logic [15:0] caddr, input logic [15:0] cwd,
                     input logic dreq, input logic dwe,
                     input logic [15:0] daddr, input logic [15:0] dwd,
                     input logic [15:0] mrd);
    logic dma_wins, cpu_wins, stalled;
    logic [15:0] e_addr, e_wd, e_crd;
    logic e_wen, e_ren;
    @(negedge clk);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; mem_rdata = mrd;
    #1;
    // DMA wins when the CPU is idle or DMA has already been refused MAX_WAIT times.
    dma_wins = !r && dreq && (!creq || (m_wait >= MAX_WAIT));
    cpu_wins = !r && creq && !dma_wins;
    stalled  = !r && creq && dma_wins;
    e_addr = 16'h0; e_wd = 16'h0; e_wen = 1'b0; e_ren = 1'b0; e_crd = 16'h0;
    if (dma_wins) begin
      e_addr = daddr; e_wd = dwd; e_wen = dwe; e_ren = !dwe;
    end else if (cpu_wins) begin
      e_addr = caddr; e_wd = cwd; e_wen = cwe; e_ren = !cwe;
      if (!cwe) e_crd = mrd;
    end
    obs_dg = dma_gnt; obs_st = cpu_stall; obs_wen = mem_wen; obs_ren = mem_ren;
    obs_addr = mem_addr; obs_wdata = mem_wdata; obs_crd = cpu_rdata;
    chk("dma_gnt",   32'(dma_gnt),   32'(dma_wins));
    chk("cpu_stall", 32'(cpu_stall), 32'(stalled));
    chk("mem_wen",   32'(mem_wen),   32'(e_wen));
    chk("mem_ren",   32'(mem_ren),   32'(e_ren));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
    @(posedge clk);
    #1;
    if (r) begin
      m_wait = 0; m_owner = 0; m_rvalid = 1'b0; m_rdata = 16'h0; m_stall = 0;
    end else begin
      if (dreq && !dma_wins) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else                   m_wait = 0;
      m_owner  = dma_wins ? 2 : (cpu_wins ? 1 : 0);
      m_rvalid = dma_wins && !dwe;
      if (m_rvalid) m_rdata = mrd;
      if (stalled && m_stall < 65535) m_stall = m_stall + 1;
    end
    chk("owner",      32'(owner),      32'(m_owner));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
    chk("dma_rdata",  32'(dma_rdata),  32'(m_rdata));
    chk("stall_cnt",  32'(stall_cnt),  32'(m_stall));
  endtask

  task automatic contend(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0);
  endtask

  initial begin
    logic creq, cwe, dreq, dwe, r;
    logic [15:0] ca, cw, da, dw;
    m_wait = 0; m_owner = 0; m_stall = 0; m_rvalid = 1'b0; m_rdata = 16'h0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;

    // T1: reset with every request active issues nothing.
    cyc(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1, 16'h3333, 16'h4444, 16'h9999);
    cyc(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3333, 16'h4444, 16'h9999);
    chk("t1_gnt", 32'(obs_dg), 32'h0);
    chk("t1_stall", 32'(obs_st), 32'h0);
    chk("t1_ren", 32'(obs_ren), 32'h0);
    chk("t1_owner", 32'(owner), 32'h0);
    chk("t1_rvalid", 32'(dma_rvalid), 32'h0);
    chk("t1_stallcnt", 32'(stall_cnt), 32'h0);

    // T2: CPU write.
    cyc(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("t2_wen", 32'(obs_wen), 32'h1);
    chk("t2_addr", 32'(obs_addr), 32'h0010);
    chk("t2_wdata", 32'(obs_wdata), 32'hBEEF);
    chk("t2_stall", 32'(obs_st), 32'h0);
    chk("t2_owner", 32'(owner), 32'h1);

    // T3: DMA read, data returned one cycle later.
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h1234);
    chk("t3_gnt", 32'(obs_dg), 32'h1);
    chk("t3_rvalid", 32'(dma_rvalid), 32'h1);
    chk("t3_rdata", 32'(dma_rdata), 32'h1234);
    cyc(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hCAFE);
    chk("t3_cpu_rdata", 32'(obs_crd), 32'hCAFE);
    chk("t3_rvalid_drop", 32'(dma_rvalid), 32'h0);
    chk("t3_rdata_hold", 32'(dma_rdata), 32'h1234);

    // T4: sustained contention gives a period-5 DMA slot.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      contend(1);
      chk("t4_stall", 32'(obs_st), 32'((i % 5) == 4));
    end
    chk("t4_stallcnt", 32'(stall_cnt), 32'd2);

    // T5: reset mid-contention discards the DMA wait history.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    contend(3);
    cyc(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0);
    for (int i = 0; i < 5; i++) begin
      contend(1);
      chk("t5_gnt", 32'(obs_dg), 32'(i == 4));
    end

    // T6: stall counter saturates.
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    m_stall = 16'hFFFE;
    contend(10);
    chk("t6_sat", 32'(stall_cnt), 32'hFFFF);

    // Randomized traffic: stalled CPU and unserved DMA keep their request stable.
    creq = 1'b0; cwe = 1'b0; ca = '0; cw = '0; dreq = 1'b0; dwe = 1'b0; da = '0; dw = '0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!(creq && obs_st) || r) begin
        creq = $urandom_range(0, 1) == 1; cwe = $urandom_range(0, 1) == 1;
        ca = 16'($urandom); cw = 16'($urandom);
      end
      if (!(dreq && !obs_dg) || r) begin
        dreq = $urandom_range(0, 2) != 0; dwe = $urandom_range(0, 1) == 1;
        da = 16'($urandom); dw = 16'($urandom);
      end
      cyc(r, creq, cwe, ca, cw, dreq, dwe, da, dw, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
